hs_rx_fifo: RTL and testbench
=============================

Name: hs_rx_fifo

Overview:
- Receive stage directly downstream of the CPU-side sender FSM.
- Implements the peripheral end of the 4-phase send/ack handshake and captures each data nibble into a small FIFO.
- Presents buffered data to the next consumer over a valid/ready interface.
- Back-pressures the sender by withholding ack when the FIFO is full.

Parameters:
- DATA_W, 4: width of handshake data and FIFO entries.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- send  in  1  sender request, level, 4-phase.
- dados  in  DATA_W  sender data; stable while send=1.
- ack  out  1  acknowledge to sender; registered.
- out_data  out  DATA_W  head-of-FIFO data.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid=1.
- count  out  $clog2(DEPTH)+1  current occupancy.
- estado  out  2  current FSM state code, for debug/display.

Behaviour:

Reset:
- Applies when rst=1 at posedge.
- Outputs: state=IDLE, ack=0, count=0, out_valid=0, out_data=0.
- Pointers are cleared. FIFO contents are don't-care.

States (estado code):
- IDLE=2'b00: ack=0.
  - send=1 and count<DEPTH → write dados to FIFO, go to ACK.
  - send=1 and count==DEPTH → go to WAIT.
  - send=0 → stay in IDLE.
- ACK=2'b01: ack=1.
  - Stay while send=1. No further writes.
  - send=0 → go to IDLE.
- WAIT=2'b10: ack=0, sender stalled.
  - count<DEPTH (registered) and send=1 → write dados, go to ACK.
  - send=0 → go to IDLE with no write; a spurious request is dropped.
- 2'b11: unused. Any entry to it goes to IDLE next cycle with ack=0.

Timing:
- ack is registered from the next state.
- send=1 sampled at edge k in IDLE with space → ack=1 and data written after edge k. Latency is 1 cycle.
- send=0 sampled at edge m in ACK → ack=0 after edge m.
- Exactly one FIFO write per handshake, regardless of how long send stays high.

FIFO:
- wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count is tracked separately.
- Pop occurs at an edge where out_valid=1 and out_ready=1.
- out_valid = (count!=0).
- out_data = mem[rd_ptr]; 0 when empty.
- Empty-to-non-empty latency: a write at edge k makes out_valid=1 after edge k.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Full plus pop in the same cycle: the full check uses the pre-edge count. The write is deferred (WAIT), and the transfer completes one cycle later.
- Pop when empty: ignored.
- Push when full: impossible by construction.

Reset mid-operation:
- FSM returns to IDLE and ack drops.
- Buffered data is discarded.
- If send is still high after reset, it is treated as a new transfer and dados is captured again. The sender must be reset in the same cycle.

Optional Feature:
- HS_SYNC_EN defined:
  - send passes through a 2-flop synchronizer, reset to 0, before the FSM. This supports a sender on an unrelated clock.
  - dados is captured when the FSM transitions to ACK, relying on the 4-phase data-stable guarantee.
  - Handshake latency grows by 2 cycles in each phase.
- HS_SYNC_EN undefined:
  - send is used directly.
  - Timing is exactly as above.

Decomposition:
- Package hs_pkg holds:
  - hs_state_t enum (IDLE, ACK, WAIT) with the 2-bit codes above.
  - HS_DATA_W_DEF=4 and HS_DEPTH_DEF=4 constants.
- One sub-module, hs_sync_fifo:
  - Holds storage, pointers, count and push/pop arithmetic, parameterised by DATA_W/DEPTH.
  - The handshake FSM stays in hs_rx_fifo.

Test Plan:
- Reset, then idle 5 cycles → ack=0, out_valid=0, count=0, estado=00.
- Single transfer: send=1 with dados=4'h3 for 3 cycles, then send=0; out_ready=0 throughout.
  - ack=1 one cycle after send rises and falls one cycle after send falls.
  - count=1, out_valid=1, out_data=4'h3; exactly one write.
- Fill and back-pressure: four handshakes with 1,2,3,4 and out_ready=0, then a fifth request with 5.
  - estado=10 and ack stays 0.
  - Pulse out_ready for one cycle → 1 popped, then 5 written, ack=1, count=4.
  - Draining yields 2,3,4,5.
- Wrap-around: 10 handshakes of 0..9 with out_ready=1 continuously.
  - Consumer sees 0..9 in order, count never exceeds 1, pointers wrap twice.
- Simultaneous push/pop at count=2: push 4'hA on the same edge as a pop.
  - count stays 2; order preserved.
- Reset during ACK with count=3 → next cycle ack=0, count=0, out_valid=0, estado=00.

Source files
------------

// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared state codes and default sizes for the handshake receive stage
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK  = 2'b01,
        WAIT = 2'b10
    } hs_state_t;

    localparam int HS_DATA_W_DEF = 4;
    localparam int HS_DEPTH_DEF  = 4;

endpackage

// File: rtl/hs_sync_fifo.sv
// rtl/hs_sync_fifo.sv - single-clock FIFO with occupancy count; DEPTH must be a power of two >= 2
module hs_sync_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty gate on data_o hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/hs_rx_fifo.sv
// rtl/hs_rx_fifo.sv - 4-phase send/ack receiver feeding a FIFO; HS_SYNC_EN adds a 2-flop send synchronizer
module hs_rx_fifo
    import hs_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W_DEF,
    parameter int DEPTH  = HS_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     send_i,
    input  logic [DATA_W-1:0]        dados_i,
    output logic                     ack_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               estado_o
);

    hs_state_t state_q, state_d;
    logic      ack_q;
    logic      send_s;
    logic      push;
    logic      full;

`ifdef HS_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], send_i};
    end

    assign send_s = sync_q[1];
`else
    assign send_s = send_i;
`endif

    // The full check uses the registered count, so a pop on the same edge defers the write via WAIT.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_s && !full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end else if (send_s) begin
                    state_d = WAIT;
                end
            end
            ACK: begin
                if (!send_s) state_d = IDLE;
            end
            WAIT: begin
                if (!send_s) begin
                    state_d = IDLE;
                end else if (!full) begin
                    push    = 1'b1;
                    state_d = ACK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == ACK);
        end
    end

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (dados_i),
        .pop_i   (out_ready_i),
        .data_o  (out_data_o),
        .valid_o (out_valid_o),
        .full_o  (full),
        .count_o (count_o)
    );

    assign ack_o    = ack_q;
    assign estado_o = state_q;

endmodule

// File: tb/tb_hs_rx_fifo.sv
// tb/tb_hs_rx_fifo.sv - scoreboard bench for hs_rx_fifo (default build)
module tb_hs_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       send;
    logic [3:0] dados;
    logic       ack;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic [1:0] estado;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] sb_q [$];

    always #5 clk = ~clk;

    hs_rx_fifo #(.DATA_W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .send_i      (send),
        .dados_i     (dados),
        .ack_o       (ack),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .count_o     (count),
        .estado_o    (estado)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
            end else begin
                chk("sb_data", {28'd0, out_data}, {28'd0, sb_q.pop_front()});
            end
        end
    end

    // One complete handshake with out_ready left as the caller set it.
    task automatic handshake(input logic [3:0] d, input logic exp_cnt_chk, input logic [2:0] exp_cnt);
        send  = 1'b1;
        dados = d;
        sb_q.push_back(d);
        tick();
        chk("hs_ack_rise", ack, 1);
        if (exp_cnt_chk) chk("hs_count", count, exp_cnt);
        send = 1'b0;
        tick();
        chk("hs_ack_fall", ack, 0);
    endtask

    initial begin
        rst = 1'b1; send = 1'b0; dados = 4'h0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_estado", estado, 0);
        chk("rst_data", out_data, 0);

        // Single transfer, send held for three cycles.
        send = 1'b1; dados = 4'h3; sb_q.push_back(4'h3);
        tick();
        chk("single_ack", ack, 1);
        chk("single_estado", estado, 1);
        chk("single_count", count, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 4'h3);
        tick(); tick();
        chk("single_one_write", count, 1);
        send = 1'b0;
        tick();
        chk("single_ack_fall", ack, 0);
        chk("single_estado_idle", estado, 0);
        chk("single_count_end", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drained", count, 0);

        // Fill to full, then a fifth request must stall in WAIT.
        for (int i = 1; i <= 4; i++) handshake(4'(i), 1'b1, 3'(i));
        send = 1'b1; dados = 4'h5; sb_q.push_back(4'h5);
        tick();
        chk("full_estado_wait", estado, 2);
        chk("full_ack_low", ack, 0);
        tick();
        chk("full_still_wait", estado, 2);
        chk("full_count", count, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_pop_count", count, 3);
        chk("full_deferred", estado, 2);
        chk("full_deferred_ack", ack, 0);
        tick();
        chk("full_write_ack", ack, 1);
        chk("full_write_count", count, 4);
        chk("full_write_estado", estado, 1);
        send = 1'b0;
        tick();
        chk("full_ack_fall", ack, 0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("full_drained", count, 0);

        // Wrap-around with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            handshake(4'(i), 1'b1, 3'd1);
            chk("wrap_count_le1", count, 0);
        end
        out_ready = 1'b0;

        // Simultaneous push and pop at count=2.
        handshake(4'hB, 1'b1, 3'd1);
        handshake(4'hC, 1'b1, 3'd2);
        send = 1'b1; dados = 4'hA; sb_q.push_back(4'hA); out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_count", count, 2);
        chk("pp_ack", ack, 1);
        send = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("pp_drained", count, 0);

        // Reset while in ACK with three entries buffered.
        handshake(4'h1, 1'b1, 3'd1);
        handshake(4'h2, 1'b1, 3'd2);
        send = 1'b1; dados = 4'h3; sb_q.push_back(4'h3);
        tick();
        chk("mid_count", count, 3);
        chk("mid_estado", estado, 1);
        rst = 1'b1; send = 1'b0;
        sb_q.delete();
        tick();
        rst = 1'b0;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_estado", estado, 0);
        chk("mid_rst_data", out_data, 0);
        tick();
        chk("sb_all_consumed", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
